// File: rtl/count_checker.sv
// count_checker: watches a free-running counter, locks onto its +1 sequence,
// and reports wrap-arounds and sequence errors with pulses and saturating
// statistics.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  SEARCH | waiting for LOCK_CYC consecutive +1 steps; nothing reported
//  LOCKED | every sample checked; wraps counted, mismatches flagged
module count_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CYC = 2,
    parameter int WRAP_W   = 8,
    parameter int ERR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [WIDTH-1:0]  cnt_in,
    input  logic              clr_stat,
    output logic              locked,
    output logic              wrap_pulse,
    output logic              err_pulse,
    output logic              err,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [ERR_W-1:0]  err_count
);

    localparam int RUN_W = (LOCK_CYC < 2) ? 1 : $clog2(LOCK_CYC + 1);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [RUN_W-1:0]   run, run_nxt;
    logic [WIDTH-1:0]   prev;
    logic [WIDTH-1:0]   prev_inc;
    logic               prev_valid;
    logic               match;
    logic               wrap_evt;
    logic               err_evt;
    logic [WRAP_W-1:0]  wrap_base, wrap_nxt;
    logic [ERR_W-1:0]   err_base, err_cnt_nxt;
    logic               err_nxt;

    assign prev_inc = prev + {{(WIDTH-1){1'b0}}, 1'b1};
    assign match    = prev_valid && (cnt_in == prev_inc);
    assign locked   = (state == LOCKED);

    // Next-state, run length and event decode.
    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        wrap_evt  = 1'b0;
        err_evt   = 1'b0;
        if (!en) begin
            // A pause drops lock silently; relock restarts from scratch.
            state_nxt = SEARCH;
            run_nxt   = '0;
        end else begin
            case (state)
                SEARCH: begin
                    if (match) begin
                        if (run == RUN_W'(LOCK_CYC - 1)) begin
                            state_nxt = LOCKED;
                            run_nxt   = '0;
                        end else begin
                            run_nxt = run + RUN_W'(1);
                        end
                    end else begin
                        run_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        wrap_evt = (prev == {WIDTH{1'b1}});
                    end else begin
                        err_evt   = 1'b1;
                        state_nxt = SEARCH;
                        run_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = SEARCH;
                    run_nxt   = '0;
                end
            endcase
        end
    end

    // Statistics: clear first, then apply this cycle's event on top, saturating.
    always_comb begin
        wrap_base   = clr_stat ? '0 : wrap_count;
        err_base    = clr_stat ? '0 : err_count;
        wrap_nxt    = wrap_base;
        err_cnt_nxt = err_base;
        if (wrap_evt && (wrap_base != {WRAP_W{1'b1}}))
            wrap_nxt = wrap_base + WRAP_W'(1);
        if (err_evt && (err_base != {ERR_W{1'b1}}))
            err_cnt_nxt = err_base + ERR_W'(1);
        err_nxt = (err && !clr_stat) || err_evt;
    end

    // State, sample history and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SEARCH;
            run        <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            wrap_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            err        <= 1'b0;
            wrap_count <= '0;
            err_count  <= '0;
        end else begin
            state      <= state_nxt;
            run        <= run_nxt;
            if (en)
                prev <= cnt_in;
            prev_valid <= en;
            wrap_pulse <= wrap_evt;
            err_pulse  <= err_evt;
            err        <= err_nxt;
            wrap_count <= wrap_nxt;
            err_count  <= err_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_count_checker.sv
// Scoreboard bench for count_checker (ERR_W=4 so saturation is reachable).
module tb_count_checker;

    logic       clk = 1'b0;
    logic       rst, en, clr_stat;
    logic [3:0] cnt_in;
    logic       locked, wrap_pulse, err_pulse, err;
    logic [7:0] wrap_count;
    logic [3:0] err_count;

    typedef struct packed {
        logic       l;
        logic       wp;
        logic       ep;
        logic       er;
        logic [7:0] wc;
        logic [3:0] ec;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 1'b0;

    count_checker #(.WIDTH(4), .LOCK_CYC(2), .WRAP_W(8), .ERR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cnt_in     (cnt_in),
        .clr_stat   (clr_stat),
        .locked     (locked),
        .wrap_pulse (wrap_pulse),
        .err_pulse  (err_pulse),
        .err        (err),
        .wrap_count (wrap_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus and queue the outputs expected after it.
    task automatic step(input logic r, input logic e, input logic [3:0] c,
                        input logic k, input logic l, input logic wp,
                        input logic ep, input logic er, input logic [7:0] wc,
                        input logic [3:0] ec);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; cnt_in = c; clr_stat = k;
        x.l = l; x.wp = wp; x.ep = ep; x.er = er; x.wc = wc; x.ec = ec;
        exp_q.push_back(x);
    endtask

    // Monitor: after each edge, compare the DUT against the oldest expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                checks++;
                if ({locked, wrap_pulse, err_pulse, err, wrap_count, err_count} !== x) begin
                    errors++;
                    $display("FAIL outputs @%0t: got l=%b wp=%b ep=%b er=%b wc=%0d ec=%0d want l=%b wp=%b ep=%b er=%b wc=%0d ec=%0d",
                             $time, locked, wrap_pulse, err_pulse, err, wrap_count, err_count,
                             x.l, x.wp, x.ep, x.er, x.wc, x.ec);
                end
            end
        end
    end

    initial begin
        logic [3:0] p, v;
        logic [3:0] ec;
        logic [7:0] wc;
        logic       wp;
        rst = 1'b1; en = 1'b0; cnt_in = '0; clr_stat = 1'b0;

        // Reset
        step(1, 0, 0, 0,  0,0,0,0, 0, 0);
        step(1, 0, 0, 0,  0,0,0,0, 0, 0);

        // Lock and wrap: 5,6,7 locks; wrap on 15->0
        step(0, 1, 5, 0,  0,0,0,0, 0, 0);
        step(0, 1, 6, 0,  0,0,0,0, 0, 0);
        step(0, 1, 7, 0,  1,0,0,0, 0, 0);
        for (int i = 8; i <= 15; i++)
            step(0, 1, 4'(i), 0,  1,0,0,0, 0, 0);
        step(0, 1, 0, 0,  1,1,0,0, 1, 0);
        step(0, 1, 1, 0,  1,0,0,0, 1, 0);
        for (int i = 2; i <= 7; i++)
            step(0, 1, 4'(i), 0,  1,0,0,0, 1, 0);

        // Error injection: 8,9,11,12,13
        step(0, 1, 8,  0,  1,0,0,0, 1, 0);
        step(0, 1, 9,  0,  1,0,0,0, 1, 0);
        step(0, 1, 11, 0,  0,0,1,1, 1, 1);
        step(0, 1, 12, 0,  0,0,0,1, 1, 1);
        step(0, 1, 13, 0,  1,0,0,1, 1, 1);

        // Pause three cycles while counter runs on, then resume 3,4,5
        step(0, 0, 14, 0,  0,0,0,1, 1, 1);
        step(0, 0, 15, 0,  0,0,0,1, 1, 1);
        step(0, 0, 0,  0,  0,0,0,1, 1, 1);
        step(0, 1, 3,  0,  0,0,0,1, 1, 1);
        step(0, 1, 4,  0,  0,0,0,1, 1, 1);
        step(0, 1, 5,  0,  1,0,0,1, 1, 1);

        // Six mismatch/relock rounds bring err_count to 7, ending locked at prev=3
        p = 4'd5; ec = 4'd1;
        for (int i = 0; i < 6; i++) begin
            v  = p + 4'd3;
            ec = ec + 4'd1;
            step(0, 1, v,        0,  0,0,1,1, 1, ec);
            step(0, 1, v + 4'd1, 0,  0,0,0,1, 1, ec);
            step(0, 1, v + 4'd2, 0,  1,0,0,1, 1, ec);
            p = v + 4'd2;
        end

        // clr_stat colliding with an error (prev=3, cnt_in=9), then without an event
        step(0, 1, 9,  1,  0,0,1,1, 0, 1);
        step(0, 1, 10, 1,  0,0,0,0, 0, 0);
        step(0, 1, 11, 0,  1,0,0,0, 0, 0);

        // Saturation: 20 mismatch/relock rounds, err_count stops at 15
        p = 4'd11; ec = 4'd0;
        for (int i = 0; i < 20; i++) begin
            v = p + 4'd3;
            if (ec != 4'd15) ec = ec + 4'd1;
            step(0, 1, v,        0,  0,0,1,1, 0, ec);
            step(0, 1, v + 4'd1, 0,  0,0,0,1, 0, ec);
            step(0, 1, v + 4'd2, 0,  1,0,0,1, 0, ec);
            p = v + 4'd2;
        end

        // Four full laps while locked -> wrap_count=4
        wc = 8'd0;
        for (int i = 0; i < 64; i++) begin
            v  = p + 4'd1;
            wp = (v == 4'd0);
            if (wp) wc = wc + 8'd1;
            step(0, 1, v, 0,  1,wp,0,1, wc, 15);
            p = v;
        end

        // Reset mid-lock, then relock in exactly three enabled samples
        step(1, 1, p + 4'd1, 0,  0,0,0,0, 0, 0);
        step(0, 1, 7, 0,  0,0,0,0, 0, 0);
        step(0, 1, 8, 0,  0,0,0,0, 0, 0);
        step(0, 1, 9, 0,  1,0,0,0, 0, 0);
        step(0, 1, 10, 0, 1,0,0,0, 0, 0);

        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        stim_done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        if (!stim_done) begin
            $display("FAIL timeout: got no finish want finish");
            $fatal(1, "timeout");
        end
    end

endmodule

// File: doc/count_checker.md
# count_checker

Synchronous monitor placed directly downstream of the 4-bit synchronous counter. Each enabled cycle it samples the counter output, locks onto a +1 (mod 2^WIDTH) sequence, and then checks every subsequent sample against the expected next value. It reports wrap-arounds and sequence errors through pulses and saturating statistics counters, so a bench or a status register can confirm the counter is healthy.

## Interface
- WIDTH, 4: width of the monitored count.
- LOCK_CYC, 2: consecutive correct increments required to lock (≥1).
- WRAP_W, 8: width of wrap_count.
- ERR_W, 8: width of err_count.

- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  check enable; low = monitor paused.
- cnt_in  in  WIDTH  counter output being monitored.
- clr_stat  in  1  clears err_count, wrap_count and err (sticky).
- locked  out  1  high while in LOCKED.
- wrap_pulse  out  1  one-cycle pulse per detected max→0 wrap while locked.
- err_pulse  out  1  one-cycle pulse per sequence error while locked.
- err  out  1  sticky error flag.
- wrap_count  out  WRAP_W  saturating wrap counter.
- err_count  out  ERR_W  saturating error counter.

## Operation
- Internal state: prev (WIDTH), prev_valid, run (counts 0..LOCK_CYC), FSM {SEARCH, LOCKED}.
- match = prev_valid && cnt_in == prev + 1 (mod 2^WIDTH).
- Every enabled cycle: prev ← cnt_in, prev_valid ← 1.
- SEARCH, en=1:
  - match: run+1; when run reaches LOCK_CYC → LOCKED, run ← 0.
  - Otherwise, including prev_valid=0: run ← 0.
  - No pulses or counts in SEARCH.
- LOCKED, en=1:
  - match with prev = 2^WIDTH−1 (cnt_in = 0): wrap_pulse, wrap_count +1 (saturating).
  - match otherwise: no action.
  - Mismatch: err_pulse, err_count +1 (saturating), err ← 1, → SEARCH, run ← 0. prev still loads cnt_in, so relock can start from the offending value.
- en=0, any state:
  - → SEARCH, prev_valid ← 0, run ← 0.
  - Pulses low; statistics and err hold.
  - Pausing is never an error.
- clr_stat=1: err_count, wrap_count and err clear. A same-cycle event is then applied on top, giving count = 1 and err = 1 for an error. clr_stat does not affect FSM or lock.
- Saturation: counters stop at all-ones and do not wrap.
- Reset (rst=1): overrides everything, including mid-lock.
  - Next-cycle state: SEARCH, prev_valid 0, run 0.
  - All outputs 0: locked, wrap_pulse, err_pulse, err, wrap_count, err_count.

## Timing
- All outputs are registered. A sample presented in cycle t is evaluated at the closing edge of t; resulting outputs are visible in cycle t+1.
- Lock latency from reset or pause: 1 + LOCK_CYC enabled samples. locked rises the cycle after the LOCK_CYC-th consecutive match.
- Loss of lock: locked falls in the same cycle err_pulse is high.
- Pulses last exactly one cycle per event. Back-to-back events pulse on consecutive cycles.
- cnt_in is assumed synchronous to clk; no input synchronizer.

## Test plan
- Lock and wrap: reset, en=1, cnt_in free-running 5,6,7,…,15,0,1 with LOCK_CYC=2.
  - locked=1 the cycle after sample 7 is evaluated.
  - A single wrap_pulse the cycle after 0 is evaluated; wrap_count=1; err=0.
- Error injection: while locked, drive 8,9,11,12,13.
  - err_pulse once (after 11), err_count=1, err=1, locked=0.
  - locked=1 again after 13 is evaluated; err stays 1.
- Pause: while locked, drop en for 3 cycles while the counter advances by 3, then resume 3,4,5.
  - No err_pulse; locked=0 during the pause; locked=1 after 5 is evaluated.
- Saturation: ERR_W=4, force 20 mismatch/relock cycles.
  - err_count holds at 15; wrap_count is unaffected.
- clr_stat collision: assert clr_stat in the cycle an error sample (prev=3, cnt_in=9) is evaluated, with err_count=7.
  - Next cycle: err_count=1, err=1.
  - With no event in that cycle: err_count=0, err=0.
- Reset mid-operation: rst=1 for one cycle while locked with wrap_count=4.
  - Next cycle: all outputs 0.
  - Relock takes exactly 3 enabled samples.
